// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } arb_state_t;

    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned TIMER_W     = 4;

endpackage

// File: rtl/access_timer.sv
// Access-length down-counter: load on grant, count down while busy, flag zero.
module access_timer
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               count,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access; MEM wins.
// Optional STALL_CNT_EN adds a saturating pipe_stall cycle counter output.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              advance,
    output logic              pipe_stall
`ifdef STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    arb_state_t state, state_n;
    logic       if_done, mem_done;
    logic       timer_zero;
    logic       fin_if, fin_mem, arb;
    logic       if_pend, mem_pend;
    logic       grant_if, grant_mem, grant;

    access_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .load_val (TIMER_W'(LATENCY - 1)),
        .count    (state != IDLE),
        .zero     (timer_zero)
    );

    // Arbitration also runs at the edge that ends an access, so a pending
    // request is chained straight into the next access without an idle gap.
    always_comb begin
        fin_if    = (state == IF_BUSY) && timer_zero;
        fin_mem   = (state == MEM_BUSY) && timer_zero;
        arb       = (state == IDLE) || fin_if || fin_mem;
        mem_pend  = mem_req && !(mem_done || fin_mem);
        if_pend   = if_req && !(if_done || fin_if);
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        state_n   = state;
        if (arb) begin
            if (mem_pend) begin
                grant_mem = 1'b1;
                state_n   = MEM_BUSY;
            end else if (if_pend) begin
                grant_if = 1'b1;
                state_n  = IF_BUSY;
            end else begin
                state_n = IDLE;
            end
        end
        grant = grant_if || grant_mem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (grant) begin
            ram_en    <= 1'b1;
            ram_we    <= grant_mem && mem_we;
            ram_addr  <= grant_mem ? mem_addr : if_addr;
            ram_wdata <= grant_mem ? mem_wdata : '0;
        end else if (fin_if || fin_mem) begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            if (fin_if) begin
                if_rdata <= ram_rdata;
            end
            if (fin_mem && !ram_we) begin
                mem_rdata <= ram_rdata;
            end
            if_done  <= (if_done && !advance) || fin_if;
            mem_done <= (mem_done && !advance) || fin_mem;
        end
    end

    assign advance = !rst && (if_req || mem_req)
                   && (if_done || !if_req) && (mem_done || !mem_req);
    assign pipe_stall = !advance;

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (pipe_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (LATENCY=2): per-cycle vector table,
// read-data scoreboard popped on advance, plus reset and back-to-back sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata, tb_rdata;
    logic        advance, pipe_stall;
    logic        ram_model;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        ifr, mr, we;
        logic [31:0] ia, ma, wd, rd;
        logic        en, rwe, adv;
        logic [31:0] addr;
        logic        push;
        logic [31:0] qi, qm;
    } vec_t;

    typedef struct {
        logic [31:0] i;
        logic [31:0] m;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    // RAM model: data is a fixed function of the address being accessed
    assign ram_rdata = ram_model ? (ram_addr ^ 32'hA5A5_0000) : tb_rdata;

    mem_port_arbiter #(
        .LATENCY (2),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .advance    (advance),
        .pipe_stall (pipe_stall)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: advance with no pending expectation", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_if_rdata"}, if_rdata, e.i);
            chk({tag, "_mem_rdata"}, mem_rdata, e.m);
        end
    endtask

    function automatic vec_t mk(logic ifr, logic mr, logic we,
                                logic [31:0] ia, logic [31:0] ma, logic [31:0] wd,
                                logic [31:0] rd, logic en, logic rwe, logic adv,
                                logic [31:0] addr, logic push,
                                logic [31:0] qi, logic [31:0] qm);
        vec_t v;
        v.ifr = ifr; v.mr = mr; v.we = we;
        v.ia = ia; v.ma = ma; v.wd = wd; v.rd = rd;
        v.en = en; v.rwe = rwe; v.adv = adv; v.addr = addr;
        v.push = push; v.qi = qi; v.qm = qm;
        return v;
    endfunction

    // Apply one cycle's inputs, check outputs mid-cycle, move to the next cycle.
    task automatic run_row(input vec_t v, input string tag);
        if_req = v.ifr; mem_req = v.mr; mem_we = v.we;
        if_addr = v.ia; mem_addr = v.ma; mem_wdata = v.wd; tb_rdata = v.rd;
        if (v.push) sb.push_back('{v.qi, v.qm});
        #1;
        chk({tag, "_ram_en"}, ram_en, v.en);
        chk({tag, "_ram_we"}, ram_we, v.rwe);
        chk({tag, "_advance"}, advance, v.adv);
        chk({tag, "_pipe_stall"}, pipe_stall, !v.adv);
        if (v.en) chk({tag, "_ram_addr"}, ram_addr, v.addr);
        if (v.rwe) chk({tag, "_ram_wdata"}, ram_wdata, v.wd);
        if (advance === 1'b1) sb_pop(tag);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; tb_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_advance", advance, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ram_model = 1'b0;

        // isolated fetch
        tbl.push_back(mk(1,0,0, 32'h40,0,0, 32'h8C010004, 0,0,0, 0, 1, 32'h8C010004, 32'h0));
        tbl.push_back(mk(1,0,0, 32'h40,0,0, 32'h8C010004, 1,0,0, 32'h40, 0, 0, 0));
        tbl.push_back(mk(1,0,0, 32'h40,0,0, 32'h8C010004, 1,0,0, 32'h40, 0, 0, 0));
        tbl.push_back(mk(1,0,0, 32'h40,0,0, 32'h8C010004, 0,0,1, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0, 32'h44,0,0, 32'h0, 0,0,0, 0, 0, 0, 0));
        // simultaneous fetch and load: MEM first, then IF
        tbl.push_back(mk(1,1,0, 32'h44,32'h100,0, 32'h55, 0,0,0, 0, 1, 32'h00221820, 32'h55));
        tbl.push_back(mk(1,1,0, 32'h44,32'h100,0, 32'h55, 1,0,0, 32'h100, 0, 0, 0));
        tbl.push_back(mk(1,1,0, 32'h44,32'h100,0, 32'h55, 1,0,0, 32'h100, 0, 0, 0));
        tbl.push_back(mk(1,1,0, 32'h44,32'h100,0, 32'h00221820, 1,0,0, 32'h44, 0, 0, 0));
        tbl.push_back(mk(1,1,0, 32'h44,32'h100,0, 32'h00221820, 1,0,0, 32'h44, 0, 0, 0));
        tbl.push_back(mk(1,1,0, 32'h44,32'h100,0, 32'h00221820, 0,0,1, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0, 32'h48,0,0, 32'h0, 0,0,0, 0, 0, 0, 0));
        // store: rdata registers keep their values
        tbl.push_back(mk(0,1,1, 32'h48,32'h200,32'hDEADBEEF, 32'h12345678, 0,0,0, 0, 1, 32'h00221820, 32'h55));
        tbl.push_back(mk(0,1,1, 32'h48,32'h200,32'hDEADBEEF, 32'h12345678, 1,1,0, 32'h200, 0, 0, 0));
        tbl.push_back(mk(0,1,1, 32'h48,32'h200,32'hDEADBEEF, 32'h12345678, 1,1,0, 32'h200, 0, 0, 0));
        tbl.push_back(mk(0,1,1, 32'h48,32'h200,32'hDEADBEEF, 32'h12345678, 0,0,1, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0, 32'h48,0,0, 32'h0, 0,0,0, 0, 0, 0, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i], $sformatf("vec%0d", i));
        end

        // reset in the second busy cycle, then a fresh full-length fetch
        run_row(mk(1,0,0, 32'h80,0,0, 32'h11111111, 0,0,0, 0, 0, 0, 0), "rst_a0");
        run_row(mk(1,0,0, 32'h80,0,0, 32'h11111111, 1,0,0, 32'h80, 0, 0, 0), "rst_a1");
        #1;
        chk("rst_a2_ram_en", ram_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ram_en", ram_en, 1'b0);
        chk("rst_mid_ram_we", ram_we, 1'b0);
        chk("rst_mid_ram_addr", ram_addr, 32'h0);
        chk("rst_mid_if_rdata", if_rdata, 32'h0);
        chk("rst_mid_mem_rdata", mem_rdata, 32'h0);
        chk("rst_mid_advance", advance, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_row(mk(1,0,0, 32'h80,0,0, 32'h22222222, 0,0,0, 0, 1, 32'h22222222, 32'h0), "rst_b0");
        run_row(mk(1,0,0, 32'h80,0,0, 32'h22222222, 1,0,0, 32'h80, 0, 0, 0), "rst_b1");
        run_row(mk(1,0,0, 32'h80,0,0, 32'h22222222, 1,0,0, 32'h80, 0, 0, 0), "rst_b2");
        run_row(mk(1,0,0, 32'h80,0,0, 32'h22222222, 0,0,1, 0, 0, 0, 0), "rst_b3");

        // back-to-back fetches, PC steps after each advance
        begin
            logic [31:0] pc;
            pc = 32'h1000;
            ram_model = 1'b1;
            mem_req = 1'b0;
            mem_we = 1'b0;
            for (int k = 0; k < 10; k++) begin
                int  cyc;
                int  en_cnt;
                bit  got_adv;
                if_req = 1'b1;
                if_addr = pc;
                sb.push_back('{pc ^ 32'hA5A5_0000, 32'h0});
                cyc = 0;
                en_cnt = 0;
                got_adv = 1'b0;
                #1;
                chk("b2b_no_double_grant", ram_en, 1'b0);
                while (!got_adv && cyc < 20) begin
                    if (advance === 1'b1) begin
                        got_adv = 1'b1;
                        sb_pop("b2b");
                    end else begin
                        if (ram_en === 1'b1) begin
                            en_cnt++;
                            chk("b2b_ram_addr", ram_addr, pc);
                        end
                        cyc++;
                        @(posedge clk);
                        #3;
                    end
                end
                chk("b2b_adv_seen", got_adv, 1'b1);
                chk("b2b_cycles", cyc, 3);
                chk("b2b_en_cycles", en_cnt, 2);
                @(posedge clk);
                #2;
                pc = pc + 32'd4;
            end
            if_req = 1'b0;
            ram_model = 1'b0;
            run_row(mk(0,0,0, 0,0,0, 0, 0,0,0, 0, 0, 0, 0), "b2b_end");
        end

        chk("sb_drained", sb.size(), 0);

`ifdef STALL_CNT_EN
        do_reset();
        chk("stall_cnt_rst", stall_cnt, 16'h0);
        repeat (5) @(posedge clk);
        #2;
        chk("stall_cnt_5", stall_cnt, 16'd5);
        repeat (70000) @(posedge clk);
        #2;
        chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning the number of cycles per RAM access (legal range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-004 SHALL have ports, one per line:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level, held until advance.
- if_addr  in  ADDR_W  PC.
- if_rdata  out  DATA_W  registered fetched word.
- mem_req  in  1  data access request (lw/sw in MEM), level.
- mem_we  in  1  1 = store.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  registered load data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- advance  out  1  pipeline may advance; drives pc_load and IF_ID_load.
- pipe_stall  out  1  ~advance; freezes all pipeline registers.

Function
REQ-005 SHALL implement FSM states IDLE, IF_BUSY, MEM_BUSY.
REQ-006 SHALL, in IDLE, grant MEM if mem_req & ~mem_done, else IF if if_req & ~if_done, else remain IDLE; MEM has fixed priority because it is the older instruction.
REQ-007 SHALL, on grant, latch the address, we and wdata into registers that drive ram_* for the whole access, load a down-counter with LATENCY-1, and enter the busy state at the next edge.
REQ-008 SHALL hold ram_en=1 for exactly LATENCY cycles per access; ram_we=mem_we for MEM accesses and 0 for IF accesses; ram_en=ram_we=0 in IDLE.
REQ-009 SHALL, at the edge ending the last busy cycle (counter==0), capture ram_rdata into if_rdata or mem_rdata (reads only), set the matching sticky done flag (if_done/mem_done), and return to IDLE.
REQ-010 SHALL have stores update no rdata register.
REQ-011 SHALL compute advance combinationally = (if_done | ~if_req) & (mem_done | ~mem_req).
REQ-012 SHALL force advance=0 when both if_req and mem_req are 0.
REQ-013 SHALL clear both done flags at the clock edge where advance=1.
REQ-014 SHALL, in the advance cycle, ignore any request whose done flag is set; a new grant is possible in the cycle after advance.
REQ-015 SHALL, if if_done is set while MEM is pending, hold if_rdata stable until advance.
REQ-016 SHALL allow no new grant while busy; a request arriving mid-access waits in IDLE for arbitration.
REQ-017 SHALL give minimum isolated-fetch latency: request cycle + LATENCY busy cycles, advance on the following cycle.

Reset
REQ-018 SHALL, on rst at any time including mid-access, immediately set state=IDLE, counter=0, both done flags=0, if_rdata=mem_rdata=0, and ram_en=ram_we=ram_addr=ram_wdata=0; advance=0 while rst is high.

Configuration
REQ-019 SHALL, with STALL_CNT_EN defined, add output stall_cnt [15:0]: it increments on every cycle with pipe_stall=1 and rst=0, saturates at 16'hFFFF, and resets to 0.
REQ-020 SHALL, without STALL_CNT_EN, omit the stall_cnt port and counter logic, with all other behaviour identical.

Structure
REQ-021 SHALL place the FSM state encoding typedef (IDLE/IF_BUSY/MEM_BUSY) and the stall-counter width constant in shared package mips_pkg.
REQ-022 SHALL implement the access-length down-counter in sub-module access_timer (load, count, zero flag).

Verification (LATENCY=2)
REQ-023 SHALL verify: if_req=1 only, if_addr=0x40, ram_rdata=0x8C010004 -> ram_en high for cycles 1-2 with ram_addr=0x40, if_rdata=0x8C010004 and advance=1 in cycle 3.
REQ-024 SHALL verify: if_req and mem_req (load, addr 0x100, RAM 0x55) both rise in cycle 0 -> MEM served in cycles 1-2, IF in cycles 3-4, advance=1 only in cycle 5, mem_rdata=0x55.
REQ-025 SHALL verify: store with mem_we=1, addr 0x200, wdata 0xDEADBEEF -> ram_we=1 with that data for 2 cycles, mem_rdata unchanged.
REQ-026 SHALL verify: rst pulsed in the second busy cycle -> ram_en=0 immediately, done flags 0, and a fresh request is re-served from IDLE with full LATENCY.
REQ-027 SHALL verify: back-to-back fetches over 10 advances -> no double-grant in the advance cycle, exactly 3 cycles per fetch.
REQ-028 SHALL verify with STALL_CNT_EN: 70000 stall cycles -> stall_cnt saturates at 0xFFFF.
